// File: rtl/xillybus_pkg.sv
// Shared helpers for the Xillybus FIFO-to-ap_fifo downsizer: width ratio, lane counter width
// and the lane-order mapping.
package xillybus_pkg;

    function automatic int unsigned ratio(input int unsigned in_w, input int unsigned out_w);
        return in_w / out_w;
    endfunction

    // Zero when there is only one lane, so callers can size the lane counter accordingly.
    function automatic int unsigned lane_w(input int unsigned r);
        return (r > 1) ? $clog2(r) : 0;
    endfunction

    function automatic int unsigned lane_sel(input int unsigned lane, input int unsigned r,
                                             input bit lsb_first);
        return lsb_first ? lane : (r - 1 - lane);
    endfunction

endpackage

// File: rtl/xillybus_apfifo_downsizer_if.sv
// FIFO read side and ap_fifo side of the downsizer; slave is the adapter, master the environment.
interface xillybus_apfifo_downsizer_if #(
    parameter int unsigned IN_W  = 128,
    parameter int unsigned OUT_W = 32
);
    logic [IN_W-1:0]  fifo_dout;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [OUT_W-1:0] in_r_dout;
    logic             in_r_empty_n;
    logic             in_r_read;

    modport master (
        output fifo_dout, fifo_empty, in_r_read,
        input  fifo_rd_en, in_r_dout, in_r_empty_n
    );

    modport slave (
        input  fifo_dout, fifo_empty, in_r_read,
        output fifo_rd_en, in_r_dout, in_r_empty_n
    );
endinterface

// File: rtl/xillybus_prefetch2.sv
// Two-entry word buffer (stage S, prefetch P) in front of a standard-mode FIFO read port.
// Tracks the outstanding read and only issues a read when its data is guaranteed a slot.
module xillybus_prefetch2 #(
    parameter int unsigned W = 128
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] fifo_dout_i,
    input  logic         fifo_empty_i,
    output logic         fifo_rd_en_o,
    input  logic         vacate_i,
    output logic [W-1:0] s_word_o,
    output logic         s_valid_o,
    output logic         busy_o
);
    logic [W-1:0] s_word_q, s_word_d, p_word_q, p_word_d;
    logic         s_valid_q, s_valid_d, p_valid_q, p_valid_d;
    logic         rd_pend_q;
    logic [1:0]   occ;
    logic         s_free;

    assign occ    = {1'b0, s_valid_q} + {1'b0, p_valid_q} + {1'b0, rd_pend_q};
    assign s_free = !s_valid_q || vacate_i;

    // At occ = 2 a read is safe only if S is leaving and P is free to absorb the in-flight word.
    assign fifo_rd_en_o = !rst_i && !fifo_empty_i &&
                          ((occ < 2'd2) || ((occ == 2'd2) && vacate_i && !p_valid_q));

    always_comb begin
        s_word_d  = s_word_q;
        p_word_d  = p_word_q;
        s_valid_d = s_valid_q;
        p_valid_d = p_valid_q;
        if (s_free) begin
            if (p_valid_q) begin
                s_word_d  = p_word_q;
                s_valid_d = 1'b1;
                p_valid_d = rd_pend_q;
                if (rd_pend_q) p_word_d = fifo_dout_i;
            end else if (rd_pend_q) begin
                s_word_d  = fifo_dout_i;
                s_valid_d = 1'b1;
            end else begin
                s_valid_d = 1'b0;
            end
        end else if (rd_pend_q) begin
            p_word_d  = fifo_dout_i;
            p_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s_word_q  <= '0;
            p_word_q  <= '0;
            s_valid_q <= 1'b0;
            p_valid_q <= 1'b0;
            rd_pend_q <= 1'b0;
        end else begin
            s_word_q  <= s_word_d;
            p_word_q  <= p_word_d;
            s_valid_q <= s_valid_d;
            p_valid_q <= p_valid_d;
            rd_pend_q <= fifo_rd_en_o;
        end
    end

    assign s_word_o  = s_word_q;
    assign s_valid_o = s_valid_q;
    assign busy_o    = (occ != 2'd0);

endmodule

// File: rtl/xillybus_apfifo_downsizer.sv
// Splits IN_W-bit FIFO words into OUT_W-bit ap_fifo beats in a configurable lane order,
// with partial-word flush and a wrapping accepted-beat counter.
module xillybus_apfifo_downsizer
    import xillybus_pkg::*;
#(
    parameter int unsigned IN_W      = 128,
    parameter int unsigned OUT_W     = 32,
    parameter bit          LSB_FIRST = 1'b1,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                          ip_clk,
    input  logic                          rst,
    xillybus_apfifo_downsizer_if.slave    bus,
    input  logic                          flush,
    output logic [CNT_W-1:0]              beat_count,
    output logic                          busy
);
    localparam int unsigned Ratio    = ratio(IN_W, OUT_W);
    localparam int unsigned LaneW    = lane_w(Ratio);
    // A single-lane design keeps a 1-bit counter that never leaves zero.
    localparam int unsigned LaneBits = (LaneW == 0) ? 1 : LaneW;

    logic [IN_W-1:0]     s_word;
    logic                s_valid;
    logic [LaneBits-1:0] lane_q, lane_d;
    logic [CNT_W-1:0]    beat_q, beat_d;
    logic                accept, last_lane, vacate;
    int unsigned         phys_lane;

    assign accept    = bus.in_r_read && s_valid;
    assign last_lane = (lane_q == LaneBits'(Ratio - 1));
    // A flush in the same cycle as an accept still counts the beat, then drops the word.
    assign vacate    = (accept && last_lane) || (flush && s_valid);

    xillybus_prefetch2 #(
        .W (IN_W)
    ) u_prefetch (
        .clk_i        (ip_clk),
        .rst_i        (rst),
        .fifo_dout_i  (bus.fifo_dout),
        .fifo_empty_i (bus.fifo_empty),
        .fifo_rd_en_o (bus.fifo_rd_en),
        .vacate_i     (vacate),
        .s_word_o     (s_word),
        .s_valid_o    (s_valid),
        .busy_o       (busy)
    );

    always_comb begin
        lane_d = lane_q;
        beat_d = beat_q;
        if (vacate) begin
            lane_d = '0;
        end else if (accept) begin
            lane_d = lane_q + LaneBits'(1);
        end
        if (accept) beat_d = beat_q + CNT_W'(1);
    end

    always_ff @(posedge ip_clk) begin
        if (rst) begin
            lane_q <= '0;
            beat_q <= '0;
        end else begin
            lane_q <= lane_d;
            beat_q <= beat_d;
        end
    end

    // Register-only mux: no path from in_r_read to in_r_dout.
    always_comb begin
        phys_lane     = lane_sel(32'(lane_q), Ratio, LSB_FIRST);
        bus.in_r_dout = s_word[phys_lane*OUT_W +: OUT_W];
    end

    assign bus.in_r_empty_n = s_valid;
    assign beat_count       = beat_q;

endmodule
